multi_cycle_control_unit: RTL and testbench

//  Main sequencer for the 16-bit multi-cycle RISC datapath. Moore FSM steps each instruction through IF/ID/EX/MEM/WB.

---
 rtl/multi_cycle_control_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_unit.sv
// Main sequencer for the 16-bit multi-cycle RISC datapath.
// A Moore FSM steps each instruction through IF/ID/EX/MEM/WB. Every datapath
// enable and mux select is decoded combinationally from the state register,
// the IR opcode and the ALU flags. Only `illegal` (and the optional counters)
// are registered.
//
// Optional feature: define CTRL_PERF_COUNTERS_EN to enable the cycle and
// retired-instruction counters. When it is undefined, both counter ports are
// tied to zero.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   op         IR opcode, stable from ID to the end of the instruction
//   zero       ALU zero flag (used in EX)
//   negative   ALU negative flag (used in EX)
//   mem_ready  data-memory completion (used in MEM)
//   state      IF=000 ID=001 EX=010 MEM=011 WB=100 HALT=111
//   pc_write   PC load enable
//   pc_src     00 PC+1, 01 branch target, 10 jump target, 11 RR
//   ir_write   IR load enable
//   rr_write   return register <- PC (CALL)
//   reg_write  register-file write enable
//   alu_src    0 busB, 1 extended immediate
//   alu_op     00 ADD, 01 SUB, 10 AND
//   ext_op     1 sign-extend, 0 zero-extend
//   mem_read   data-memory read strobe
//   mem_write  data-memory write strobe
//   mem_to_reg WB source: 1 memory, 0 ALU
//   illegal    sticky flag: reserved opcode decoded
//   cycle_cnt  cycles since reset (optional)
//   instr_cnt  retired instructions (optional)
module multi_cycle_control_unit #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             negative,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             rr_write,
  output logic             reg_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BGT  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_CALL = OP_W'(12);
  localparam logic [OP_W-1:0] OP_RET  = OP_W'(13);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  state_t cur, nxt;
  logic   rsv;
  logic   taken;

  // Everything above RET is reserved (14 and 15 for the 4-bit opcode).
  assign rsv   = (op > OP_RET);
  assign taken = ((op == OP_BEQ) &&  zero) ||
                 ((op == OP_BNE) && !zero) ||
                 ((op == OP_BGT) && !zero && !negative) ||
                 ((op == OP_BLT) &&  negative);

  assign state = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_IF;
    else        cur <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 illegal <= 1'b0;
    else if (cur == S_ID && rsv) illegal <= 1'b1;
  end

  always_comb begin
    nxt        = cur;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    rr_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    ext_op     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (cur)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        nxt      = S_ID;
      end
      S_ID: begin
        if (op == OP_JMP) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          nxt      = S_IF;
        end else if (op == OP_CALL) begin
          rr_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = 2'b10;
          nxt      = S_IF;
        end else if (op == OP_RET) begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
          nxt      = S_IF;
        end else if (rsv) begin
          nxt = S_HALT;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        // Unreachable opcodes fall back to fetch rather than wedging.
        nxt = S_IF;
        case (op)
          OP_AND: begin alu_op = 2'b10; nxt = S_WB; end
          OP_ADD: begin alu_op = 2'b00; nxt = S_WB; end
          OP_SUB: begin alu_op = 2'b01; nxt = S_WB; end
          OP_ADDI: begin
            alu_src = 1'b1;
            ext_op  = 1'b1;
            nxt     = S_WB;
          end
          OP_ANDI: begin
            alu_src = 1'b1;
            alu_op  = 2'b10;
            nxt     = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            ext_op  = 1'b1;
            nxt     = S_MEM;
          end
          OP_BEQ, OP_BNE, OP_BGT, OP_BLT: begin
            alu_op = 2'b01;
            if (taken) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_read  = (op == OP_LW);
        mem_write = (op == OP_SW);
        if (mem_ready) nxt = (op == OP_LW) ? S_WB : S_IF;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op == OP_LW);
        nxt        = S_IF;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
    // Reset is asynchronous, so the strobes must drop the moment it asserts,
    // not at the next edge.
    if (!reset) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      rr_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      ext_op     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

`ifdef CTRL_PERF_COUNTERS_EN
  logic             retire;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ins_q;

  // Any transition back into IF retires an instruction; IF itself never
  // returns to IF and HALT never leaves, so no further qualification is needed.
  assign retire = (nxt == S_IF) && (cur != S_IF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (retire) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench for multi_cycle_control_unit: a directed table of
// per-cycle vectors, hand-written reset and HALT sequences, and randomized
// instruction streams checked against an instruction-class reference model.
module tb_multi_cycle_control_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic        zero;
  logic        negative;
  logic        mem_ready;
  logic [2:0]  state;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        rr_write;
  logic        reg_write;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        ext_op;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        illegal;
  logic [15:0] cycle_cnt;
  logic [15:0] instr_cnt;

  multi_cycle_control_unit #(.OP_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .negative(negative),
    .mem_ready(mem_ready), .state(state), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .rr_write(rr_write), .reg_write(reg_write),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rrw;
    logic       rw;
    logic       asrc;
    logic [1:0] aop;
    logic       ext;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic [3:0] op;
    logic       z;
    logic       n;
    logic       rdy;
    logic       last;
    outs_t      exp;
  } vec_t;

  vec_t        vecs[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] exp_cyc = '0;
  logic [15:0] exp_ins = '0;

  function automatic outs_t mk(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                               input logic irw, input logic rrw, input logic rw, input logic asrc,
                               input logic [1:0] aop, input logic ext, input logic mr,
                               input logic mw, input logic m2r, input logic ill);
    outs_t o;
    o = {st, pcw, pcs, irw, rrw, rw, asrc, aop, ext, mr, mw, m2r, ill};
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o = {state, pc_write, pc_src, ir_write, rr_write, reg_write, alu_src, alu_op,
         ext_op, mem_read, mem_write, mem_to_reg, illegal};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_cnt(input string tag);
`ifdef CTRL_PERF_COUNTERS_EN
    check({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(exp_cyc));
    check({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(exp_ins));
`else
    check({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'd0);
    check({tag, ".instr_cnt"}, 32'(instr_cnt), 32'd0);
`endif
  endtask

  task automatic push(input logic [3:0] o, input logic z, input logic n, input logic rdy,
                      input logic last, input outs_t e);
    vec_t v;
    v = {o, z, n, rdy, last, e};
    vecs.push_back(v);
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, then let
  // the rising edge consume them.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    op = v.op; zero = v.z; negative = v.n; mem_ready = v.rdy;
    #1;
    check({tag, ".outs"}, 32'(dut_outs()), 32'(v.exp));
    chk_cnt(tag);
    @(posedge clk);
    exp_cyc++;
    if (v.last) exp_ins++;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("%s[%0d]", tag, i));
    vecs.delete();
  endtask

  // Reference model: expands one instruction into its per-cycle vectors from
  // its class (ALU, immediate, memory, branch, jump), the latency rules and
  // the branch conditions. Inputs the design must ignore get random values.
  task automatic gen_instr(input logic [3:0] o, input logic z, input logic n, input int waits);
    outs_t e;
    bit    is_jump   = (o >= 11 && o <= 13);
    bit    is_branch = (o >= 7 && o <= 10);
    bit    is_mem    = (o == 5 || o == 6);
    bit    is_rsv    = (o >= 14);
    bit    tk;
    e = '0; e.st = 3'd0; e.irw = 1'b1; e.pcw = 1'b1;
    push(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, e);
    e = '0; e.st = 3'd1;
    if (is_jump) begin
      e.pcw = 1'b1;
      e.pcs = (o == 13) ? 2'd3 : 2'd2;
      e.rrw = (o == 12);
    end
    push(o, 1'($urandom), 1'($urandom), 1'($urandom), is_jump, e);
    if (is_jump || is_rsv) return;
    e = '0; e.st = 3'd2;
    case (o)
      4'd0: e.aop = 2'd2;
      4'd1: e.aop = 2'd0;
      4'd2: e.aop = 2'd1;
      4'd4: begin e.asrc = 1'b1; e.aop = 2'd2; end
      4'd3, 4'd5, 4'd6: begin e.asrc = 1'b1; e.ext = 1'b1; end
      default: begin
        e.aop = 2'd1;
        case (o)
          4'd7:    tk = z;
          4'd8:    tk = !z;
          4'd9:    tk = !z && !n;
          default: tk = n;
        endcase
        if (tk) begin e.pcw = 1'b1; e.pcs = 2'd1; end
      end
    endcase
    push(o, z, n, 1'($urandom), is_branch, e);
    if (is_branch) return;
    if (is_mem) begin
      for (int w = 0; w <= waits; w++) begin
        e = '0; e.st = 3'd3; e.mr = (o == 5); e.mw = (o == 6);
        push(o, 1'($urandom), 1'($urandom), (w == waits), (o == 6 && w == waits), e);
      end
      if (o == 6) return;
    end
    e = '0; e.st = 3'd4; e.rw = 1'b1; e.m2r = (o == 5);
    push(o, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, e);
  endtask

  initial begin
    outs_t F, D, Z;
    F = mk(3'd0, 1, 2'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    D = mk(3'd1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    Z = '0;

    // Power-up reset: everything low, including fetch enables.
    reset = 1'b0; op = 4'd0; zero = 1'b0; negative = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset.outs", 32'(dut_outs()), 32'(Z));
    chk_cnt("reset");
    @(posedge clk); #2;
    reset = 1'b1;

    // Directed table: ADD, LW, branches, jumps, ALU variants, SW with waits.
    push(1, 0, 0, 1, 0, F); push(1, 0, 0, 1, 0, D);
    push(1, 0, 0, 1, 0, mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    push(1, 0, 0, 1, 1, mk(3'd4, 0, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0));
    push(5, 0, 0, 1, 0, F); push(5, 0, 0, 1, 0, D);
    push(5, 0, 0, 1, 0, mk(3'd2, 0, 2'd0, 0, 0, 0, 1, 2'd0, 1, 0, 0, 0, 0));
    push(5, 0, 0, 1, 0, mk(3'd3, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0));
    push(5, 0, 0, 1, 1, mk(3'd4, 0, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 1, 0));
    push(9, 0, 0, 1, 0, F); push(9, 0, 0, 1, 0, D);
    push(9, 0, 0, 1, 1, mk(3'd2, 1, 2'd1, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0));
    push(10, 0, 0, 1, 0, F); push(10, 0, 0, 1, 0, D);
    push(10, 0, 0, 1, 1, mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0));
    push(7, 1, 0, 1, 0, F); push(7, 1, 0, 1, 0, D);
    push(7, 1, 0, 1, 1, mk(3'd2, 1, 2'd1, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0));
    push(12, 0, 0, 1, 0, F);
    push(12, 0, 0, 1, 1, mk(3'd1, 1, 2'd2, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    push(13, 0, 0, 1, 0, F);
    push(13, 0, 0, 1, 1, mk(3'd1, 1, 2'd3, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    push(11, 0, 0, 1, 0, F);
    push(11, 0, 0, 1, 1, mk(3'd1, 1, 2'd2, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    push(2, 0, 0, 1, 0, F); push(2, 0, 0, 1, 0, D);
    push(2, 0, 0, 1, 0, mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0));
    push(2, 0, 0, 1, 1, mk(3'd4, 0, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0));
    push(0, 0, 0, 1, 0, F); push(0, 0, 0, 1, 0, D);
    push(0, 0, 0, 1, 0, mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0));
    push(0, 0, 0, 1, 1, mk(3'd4, 0, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0));
    push(4, 0, 0, 1, 0, F); push(4, 0, 0, 1, 0, D);
    push(4, 0, 0, 1, 0, mk(3'd2, 0, 2'd0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0));
    push(4, 0, 0, 1, 1, mk(3'd4, 0, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0));
    push(3, 0, 0, 1, 0, F); push(3, 0, 0, 1, 0, D);
    push(3, 0, 0, 1, 0, mk(3'd2, 0, 2'd0, 0, 0, 0, 1, 2'd0, 1, 0, 0, 0, 0));
    push(3, 0, 0, 1, 1, mk(3'd4, 0, 2'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0));
    push(6, 0, 0, 1, 0, F); push(6, 0, 0, 1, 0, D);
    push(6, 0, 0, 0, 0, mk(3'd2, 0, 2'd0, 0, 0, 0, 1, 2'd0, 1, 0, 0, 0, 0));
    for (int w = 0; w < 4; w++)
      push(6, 0, 0, (w == 3), (w == 3), mk(3'd3, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0));
    push(1, 0, 0, 1, 0, F);
    run_vecs("dir");

    // Reset asserted in the middle of ADD's EX cycle.
    push(1, 0, 0, 1, 0, D);
    run_vecs("rstseq");
    @(negedge clk); op = 4'd1; zero = 1'b1; negative = 1'b0; mem_ready = 1'b1; #1;
    check("midex.ex", 32'(dut_outs()), 32'(mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0)));
    #1 reset = 1'b0;
    exp_cyc = '0; exp_ins = '0;
    #1;
    check("midex.async", 32'(dut_outs()), 32'(Z));
    @(posedge clk);
    @(negedge clk); #1;
    check("midex.held", 32'(dut_outs()), 32'(Z));
    chk_cnt("midex");
    @(posedge clk); #2;
    reset = 1'b1;

    // Randomized instruction stream against the reference model.
    for (int k = 0; k < 80; k++)
      gen_instr(4'($urandom_range(0, 13)), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    run_vecs("rnd");

    // Reserved opcode: HALT with all enables low; counters per configuration.
    gen_instr(4'd15, 1'b0, 1'b0, 0);
    for (int h = 0; h < 20; h++)
      push(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
           mk(3'd7, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
    run_vecs("halt");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
